execute_cycle: RTL
==================

// Module: execute_cycle
// PURPOSE
//  EX stage of the 5-stage RV32I pipeline: consumes the ID/EX register outputs from the decode stage.
//  Selects forwarded operands, runs the ALU, resolves beq and computes the branch target.
//  Registers results into the EX/MEM pipeline register that feeds the memory stage.
//  Branch redirect (PCSrcE, PCTargetE) is combinational back to the fetch stage.
// PARAMETERS
//  XLEN  32  datapath width (operands, PC, immediates)
//  RADDR 5   register-address width
// PORTS
//  clk          in   1     rising-edge clock (the only clock)
//  rst          in   1     asynchronous, active-low reset
//  RegWriteE    in   1     register-writeback enable from ID/EX
//  ALUSrcE      in   1     0: SrcB = forwarded RD2; 1: SrcB = Imm_Ext_E
//  MemWriteE    in   1     store enable
//  ResultSrcE   in   1     0: writeback ALU result; 1: writeback load data
//  BranchE      in   1     instruction is beq
//  ALUControlE  in   3     000 add, 001 sub, 010 and, 011 or, 101 slt; others give 0
//  RD1_E        in   XLEN  rs1 value read in ID
//  RD2_E        in   XLEN  rs2 value read in ID
//  Imm_Ext_E    in   XLEN  sign-extended immediate
//  RD_E         in   RADDR destination register
//  PCE          in   XLEN  PC of the instruction
//  PCPlus4E     in   XLEN  PC+4 of the instruction
//  ResultW      in   XLEN  writeback-stage result, used for forwarding
//  ForwardA_E   in   2     rs1 source: 00 RD1_E, 01 ResultW, 10 ALU_ResultM, 11 RD1_E
//  ForwardB_E   in   2     rs2 source: same encoding, applied to RD2_E
//  PCSrcE       out  1     take branch (combinational)
//  PCTargetE    out  XLEN  PCE + Imm_Ext_E (combinational)
//  RegWriteM    out  1     registered copy of RegWriteE
//  MemWriteM    out  1     registered copy of MemWriteE
//  ResultSrcM   out  1     registered copy of ResultSrcE
//  RD_M         out  RADDR registered copy of RD_E
//  PCPlus4M     out  XLEN  registered copy of PCPlus4E
//  WriteDataM   out  XLEN  registered forwarded rs2 (store data)
//  ALU_ResultM  out  XLEN  registered ALU result
// BEHAVIOUR
//  - Reset (rst = 0, asynchronous): all M-side outputs clear to 0 immediately. Clock is not required.
//    Reset mid-operation discards the in-flight instruction: an all-zero EX/MEM holds no write and no store.
//  - SrcA = mux(ForwardA_E); fwdB = mux(ForwardB_E); SrcB = ALUSrcE ? Imm_Ext_E : fwdB.
//  - The forward path 10 uses this block's own registered ALU_ResultM output.
//  - ALU arithmetic is modulo 2^XLEN; overflow and carry are discarded.
//  - slt is a signed compare; the result is 1 or 0, zero-extended.
//  - ZeroE = (ALU result == 0).
//  - PCSrcE = BranchE & ZeroE. PCTargetE wraps modulo 2^XLEN.
//    Both are pure combinational functions of the current inputs and ALU_ResultM; they are valid within the cycle.
//  - Latency: all registered outputs take the E-side values 1 cycle after the E-side inputs (every rising edge).
//  - There is no enable, stall or flush. Bubbles arrive as all-zero control from ID/EX and propagate unchanged.
//  - Reset release is synchronous-safe: the first capture happens on the first rising edge with rst = 1.
//  - Forward select 11 is reserved and behaves as 00 (no X propagation).
// TESTING
//  - Reset: rst = 0 asserted mid-clock with nonzero inputs -> all M outputs 0 before the next edge;
//    they stay 0 while rst = 0.
//  - add/sub: RD1_E = 5, RD2_E = 3, ALUSrcE = 0; ALUControlE = 000 then 001 -> ALU_ResultM = 8, then 2,
//    each 1 cycle later.
//    Also: 0xFFFFFFFF + 1 -> 0.
//  - slt signed: RD1_E = 0xFFFFFFFF (-1), RD2_E = 1, ALUControlE = 101 -> ALU_ResultM = 1.
//    Swapped operands -> 0.
//  - Immediate and store: ALUSrcE = 1, Imm_Ext_E = 0x10, RD1_E = 0x100, RD2_E = 0xAB, MemWriteE = 1
//    -> ALU_ResultM = 0x110, WriteDataM = 0xAB, MemWriteM = 1.
//  - Forwarding: prior cycle leaves ALU_ResultM = 7; ForwardA_E = 10, ForwardB_E = 01, ResultW = 2, add
//    -> ALU_ResultM = 9; WriteDataM = 2.
//  - Branch: BranchE = 1, sub with 4 - 4, PCE = 0x20, Imm_Ext_E = 0xFFFFFFF8
//    -> PCSrcE = 1 and PCTargetE = 0x18 in the same cycle.
//    With 4 - 5 -> PCSrcE = 0.

Source files
------------

// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU, beq resolution,
// branch target generation and the EX/MEM pipeline register.
module execute_cycle #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic             ALUSrcE,
  input  logic             MemWriteE,
  input  logic             ResultSrcE,
  input  logic             BranchE,
  input  logic [2:0]       ALUControlE,
  input  logic [XLEN-1:0]  RD1_E,
  input  logic [XLEN-1:0]  RD2_E,
  input  logic [XLEN-1:0]  Imm_Ext_E,
  input  logic [RADDR-1:0] RD_E,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  PCPlus4E,
  input  logic [XLEN-1:0]  ResultW,
  input  logic [1:0]       ForwardA_E,
  input  logic [1:0]       ForwardB_E,
  output logic             PCSrcE,
  output logic [XLEN-1:0]  PCTargetE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ResultSrcM,
  output logic [RADDR-1:0] RD_M,
  output logic [XLEN-1:0]  PCPlus4M,
  output logic [XLEN-1:0]  WriteDataM,
  output logic [XLEN-1:0]  ALU_ResultM
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero_e;

  // Reserved select 11 falls back to the register-file value so no X escapes.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero_e    = (alu_result == '0);
  assign PCSrcE    = BranchE & zero_e;
  assign PCTargetE = PCE + Imm_Ext_E;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= alu_result;
    end
  end

endmodule
